// File: rtl/square_field.sv
// ============================================================================
// Module   : square_field
// Purpose  : Falling-square positions, per-update catch/miss judging and
//            erase/draw rasterisation of every square to the pixel interface.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module square_field #(
   parameter int         N_SQUARES = 4,
   parameter int         SIZE      = 4,
   parameter int         STEP      = 1,
   parameter int         SCREEN_W  = 160,
   parameter int         SCREEN_H  = 120,
   parameter int         CATCHER_W = 16,
   parameter logic [2:0] SQ_COLOUR = 3'b100,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       update,
   input  logic       draw_squares,
   input  logic [7:0] catcher_x,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour,
   output logic       pixel_valid,
   output logic       finish_drawing_squares,
   output logic [3:0] catch_count,
   output logic [3:0] miss_count,
   output logic       stats_valid
);

   localparam int         c_idx_w = (N_SQUARES > 1) ? $clog2(N_SQUARES) : 1;
   localparam int         c_off_w = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [7:0] c_span  = 8'(SCREEN_W - SIZE);

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [c_idx_w-1:0]  r_s, w_s_nxt;
   logic [c_off_w-1:0]  r_px, r_py, w_px_nxt, w_py_nxt;
   logic [7:0]          r_lfsr;
   logic [7:0]          r_x      [N_SQUARES];
   logic [6:0]          r_y      [N_SQUARES];
   logic [7:0]          r_prev_x [N_SQUARES];
   logic [6:0]          r_prev_y [N_SQUARES];

   logic                w_emit, w_erase, w_last_pix, w_save_prev, w_finish_nxt;
   logic                w_upd;
   logic [7:0]          w_src_x;
   logic [6:0]          w_src_y;

   logic [7:0]          r_pix_x;
   logic [6:0]          r_pix_y;
   logic [2:0]          r_colour;
   logic                r_valid, r_finish, r_stats_valid;
   logic [3:0]          r_catch, r_miss;

   logic [7:0]          w_rot    [N_SQUARES];
   logic [8:0]          w_bottom [N_SQUARES];
   logic [8:0]          w_left   [N_SQUARES];
   logic [7:0]          w_new_x  [N_SQUARES];
   logic [6:0]          w_new_y  [N_SQUARES];
   logic [N_SQUARES-1:0] w_land, w_hit;
   logic [3:0]          w_catch_cnt, w_miss_cnt;

   assign w_upd      = update && (r_state == IDLE);
   assign w_last_pix = (r_px == c_off_w'(SIZE - 1)) && (r_py == c_off_w'(SIZE - 1));

   // IDLE doubles as the first erase cycle so the first pixel leaves one cycle after the request.
   always_comb begin
      w_state_nxt  = r_state;
      w_s_nxt      = r_s;
      w_px_nxt     = r_px;
      w_py_nxt     = r_py;
      w_emit       = 1'b0;
      w_erase      = 1'b0;
      w_save_prev  = 1'b0;
      w_finish_nxt = 1'b0;
      case (r_state)
         IDLE, ERASE: begin
            if (r_state == ERASE || draw_squares) begin
               w_emit  = 1'b1;
               w_erase = 1'b1;
               if (w_last_pix) begin
                  w_px_nxt    = '0;
                  w_py_nxt    = '0;
                  w_state_nxt = DRAW;
               end else begin
                  w_state_nxt = ERASE;
                  if (r_px == c_off_w'(SIZE - 1)) begin
                     w_px_nxt = '0;
                     w_py_nxt = r_py + c_off_w'(1);
                  end else begin
                     w_px_nxt = r_px + c_off_w'(1);
                  end
               end
            end
         end
         DRAW: begin
            w_emit = 1'b1;
            if (w_last_pix) begin
               w_save_prev = 1'b1;
               w_px_nxt    = '0;
               w_py_nxt    = '0;
               if (r_s == c_idx_w'(N_SQUARES - 1)) begin
                  w_s_nxt     = '0;
                  w_state_nxt = DONE;
               end else begin
                  w_s_nxt     = r_s + c_idx_w'(1);
                  w_state_nxt = ERASE;
               end
            end else if (r_px == c_off_w'(SIZE - 1)) begin
               w_px_nxt = '0;
               w_py_nxt = r_py + c_off_w'(1);
            end else begin
               w_px_nxt = r_px + c_off_w'(1);
            end
         end
         DONE: begin
            // finish is always shown for at least one cycle before returning to IDLE
            w_finish_nxt = !(r_finish && !draw_squares);
            if (r_finish && !draw_squares) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_src_x = w_erase ? r_prev_x[r_s] : r_x[r_s];
   assign w_src_y = w_erase ? r_prev_y[r_s] : r_y[r_s];

   always_comb begin
      w_catch_cnt = '0;
      w_miss_cnt  = '0;
      for (int i = 0; i < N_SQUARES; i++) begin
         w_rot[i]    = (r_lfsr << i) | (r_lfsr >> (8 - i));
         w_bottom[i] = {2'b00, r_y[i]} + 9'(STEP) + 9'(SIZE);
         w_land[i]   = w_bottom[i] > 9'(SCREEN_H);
         w_left[i]   = {1'b0, r_x[i]};
         w_hit[i]    = ((w_left[i] + 9'(SIZE)) > {1'b0, catcher_x}) &&
                       (w_left[i] < ({1'b0, catcher_x} + 9'(CATCHER_W)));
         w_new_x[i]  = r_x[i];
         w_new_y[i]  = r_y[i] + 7'(STEP);
         if (w_land[i]) begin
            w_new_x[i] = (w_rot[i] >= c_span) ? (w_rot[i] - c_span) : w_rot[i];
            w_new_y[i] = '0;
            if (w_hit[i]) begin
               w_catch_cnt = w_catch_cnt + 4'd1;
            end else begin
               w_miss_cnt = w_miss_cnt + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_s           <= '0;
         r_px          <= '0;
         r_py          <= '0;
         r_lfsr        <= 8'hA5;
         r_pix_x       <= '0;
         r_pix_y       <= '0;
         r_colour      <= '0;
         r_valid       <= 1'b0;
         r_finish      <= 1'b0;
         r_stats_valid <= 1'b0;
         r_catch       <= '0;
         r_miss        <= '0;
         for (int i = 0; i < N_SQUARES; i++) begin
            r_x[i]      <= 8'(i * (SCREEN_W / N_SQUARES));
            r_y[i]      <= 7'(i * (SCREEN_H / N_SQUARES));
            r_prev_x[i] <= 8'(i * (SCREEN_W / N_SQUARES));
            r_prev_y[i] <= 7'(i * (SCREEN_H / N_SQUARES));
         end
      end else begin
         r_lfsr   <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
         r_state  <= w_state_nxt;
         r_s      <= w_s_nxt;
         r_px     <= w_px_nxt;
         r_py     <= w_py_nxt;
         r_valid  <= w_emit;
         r_finish <= w_finish_nxt;
         if (w_emit) begin
            r_pix_x  <= w_src_x + 8'(r_px);
            r_pix_y  <= w_src_y + 7'(r_py);
            r_colour <= w_erase ? BG_COLOUR : SQ_COLOUR;
         end
         if (w_save_prev) begin
            r_prev_x[r_s] <= r_x[r_s];
            r_prev_y[r_s] <= r_y[r_s];
         end
         r_stats_valid <= w_upd;
         if (w_upd) begin
            r_catch <= w_catch_cnt;
            r_miss  <= w_miss_cnt;
            for (int i = 0; i < N_SQUARES; i++) begin
               r_x[i] <= w_new_x[i];
               r_y[i] <= w_new_y[i];
            end
         end
      end
   end

   assign x_out                  = r_pix_x;
   assign y_out                  = r_pix_y;
   assign colour                 = r_colour;
   assign pixel_valid            = r_valid;
   assign finish_drawing_squares = r_finish;
   assign catch_count            = r_catch;
   assign miss_count             = r_miss;
   assign stats_valid            = r_stats_valid;

endmodule

`default_nettype wire

// File: tb/tb_square_field.sv
// ============================================================================
// Module   : tb_square_field
// Purpose  : Scoreboard bench for square_field: pixel and stats queues drained
//            by a negedge monitor, plus directed hand-computed checks.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_square_field;

   localparam int         N_SQUARES = 4;
   localparam int         SIZE      = 4;
   localparam int         STEP      = 1;
   localparam int         SCREEN_W  = 160;
   localparam int         SCREEN_H  = 120;
   localparam int         CATCHER_W = 16;
   localparam logic [2:0] SQ        = 3'b100;
   localparam logic [2:0] BG        = 3'b000;

   logic       clock;
   logic       reset;
   logic       update;
   logic       draw_squares;
   logic [7:0] catcher_x;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour;
   logic       pixel_valid;
   logic       finish_drawing_squares;
   logic [3:0] catch_count;
   logic [3:0] miss_count;
   logic       stats_valid;

   square_field dut (
      .clock                  (clock),
      .reset                  (reset),
      .update                 (update),
      .draw_squares           (draw_squares),
      .catcher_x              (catcher_x),
      .x_out                  (x_out),
      .y_out                  (y_out),
      .colour                 (colour),
      .pixel_valid            (pixel_valid),
      .finish_drawing_squares (finish_drawing_squares),
      .catch_count            (catch_count),
      .miss_count             (miss_count),
      .stats_valid            (stats_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   logic [17:0] sq_pix   [$];
   logic [7:0]  sq_stats [$];
   logic [17:0] cap [256];
   int          pidx = 0;
   int          mx [N_SQUARES];
   int          my [N_SQUARES];
   int          mpx [N_SQUARES];
   int          mpy [N_SQUARES];
   logic [7:0]  m_lfsr;

   // reference LFSR: Fibonacci, taps 8,6,5,4
   always @(posedge clock or negedge reset) begin
      if (!reset) m_lfsr <= 8'hA5;
      else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) r[(b + n) % 8] = v[b];
      return r;
   endfunction

   function automatic logic [31:0] all_outs();
      return {3'b000, x_out, y_out, colour, pixel_valid, finish_drawing_squares,
              catch_count, miss_count, stats_valid};
   endfunction

   task automatic model_init();
      for (int i = 0; i < N_SQUARES; i++) begin
         mx[i]  = i * (SCREEN_W / N_SQUARES);
         my[i]  = i * (SCREEN_H / N_SQUARES);
         mpx[i] = mx[i];
         mpy[i] = my[i];
      end
   endtask

   task automatic monitor_step();
      logic [17:0] e;
      logic [7:0]  es;
      if (reset !== 1'b1) return;
      if (pixel_valid) begin
         cap[pidx] = {x_out, y_out, colour};
         if (pidx < 255) pidx++;
         if (sq_pix.size() == 0) begin
            checks++; errors++;
            $display("FAIL pixel_unexpected actual=%0h required=none", {x_out, y_out, colour});
         end else begin
            e = sq_pix.pop_front();
            chk("pixel", {14'd0, x_out, y_out, colour}, {14'd0, e});
         end
      end else begin
         pidx = 0;
      end
      if (stats_valid) begin
         if (sq_stats.size() == 0) begin
            checks++; errors++;
            $display("FAIL stats_unexpected actual=%0h required=none", {catch_count, miss_count});
         end else begin
            es = sq_stats.pop_front();
            chk("stats", {24'd0, catch_count, miss_count}, {24'd0, es});
         end
      end
   endtask

   task automatic do_update(input logic [7:0] cx);
      int c;
      int m;
      logic [7:0] r;
      @(negedge clock);
      catcher_x = cx;
      update    = 1'b1;
      c = 0;
      m = 0;
      for (int i = 0; i < N_SQUARES; i++) begin
         if (my[i] + STEP + SIZE > SCREEN_H) begin
            if ((mx[i] + SIZE > int'(cx)) && (mx[i] < int'(cx) + CATCHER_W)) c++;
            else m++;
            r = rotl(m_lfsr, i);
            mx[i] = (int'(r) >= SCREEN_W - SIZE) ? int'(r) - (SCREEN_W - SIZE) : int'(r);
            my[i] = 0;
         end else begin
            my[i] = my[i] + STEP;
         end
      end
      sq_stats.push_back({4'(c), 4'(m)});
      @(negedge clock);
      update = 1'b0;
      chk("stats_pulse", {31'd0, stats_valid}, 32'd1);
   endtask

   task automatic do_abort();
      #2 reset = 1'b0;
      #1 chk("reset_outputs_zero", all_outs(), 32'd0);
      sq_pix.delete();
      sq_stats.delete();
      draw_squares = 1'b0;
      update       = 1'b0;
      model_init();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic run_pass(input int abort_at, input int upd_at);
      int run;
      bit fin_early;
      for (int s = 0; s < N_SQUARES; s++) begin
         for (int py = 0; py < SIZE; py++)
            for (int px = 0; px < SIZE; px++)
               sq_pix.push_back({8'(mpx[s] + px), 7'(mpy[s] + py), BG});
         for (int py = 0; py < SIZE; py++)
            for (int px = 0; px < SIZE; px++)
               sq_pix.push_back({8'(mx[s] + px), 7'(my[s] + py), SQ});
      end
      @(negedge clock);
      draw_squares = 1'b1;
      run       = 0;
      fin_early = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         if (upd_at >= 0 && run == upd_at) update = 1'b1;
         if (upd_at >= 0 && run == upd_at + 1) begin
            update = 1'b0;
            chk("no_stats_in_draw", {31'd0, stats_valid}, 32'd0);
         end
         if (abort_at >= 0 && run == abort_at) begin
            do_abort();
            return;
         end
         if (!pixel_valid) break;
         if (finish_drawing_squares) fin_early = 1'b1;
         run++;
      end
      chk("valid_run_len", run, 2 * N_SQUARES * SIZE * SIZE);
      chk("finish_rise", {31'd0, finish_drawing_squares}, 32'd1);
      chk("finish_not_early", {31'd0, fin_early}, 32'd0);
      chk("pixel_queue_drained", sq_pix.size(), 32'd0);
      sq_pix.delete();
      draw_squares = 1'b0;
      @(negedge clock);
      chk("finish_drop", {31'd0, finish_drawing_squares}, 32'd0);
      for (int s = 0; s < N_SQUARES; s++) begin
         mpx[s] = mx[s];
         mpy[s] = my[s];
      end
   endtask

   initial begin
      reset        = 1'b0;
      update       = 1'b0;
      draw_squares = 1'b0;
      catcher_x    = 8'd0;
      model_init();
      fork
         forever begin
            @(negedge clock);
            monitor_step();
         end
      join_none

      #3 chk("reset_outputs", all_outs(), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("idle_outputs", all_outs(), 32'd0);

      // first pass: erase then draw of each square at its reset position
      run_pass(-1, -1);
      chk("p1_first_pixel", {14'd0, cap[0]}, {14'd0, 8'd0, 7'd0, BG});
      for (int k = 16; k < 32; k++)
         chk("p1_square0_draw", {14'd0, cap[k]}, {14'd0, 8'(k % 4), 7'((k - 16) / 4), SQ});

      do_update(8'd0);
      chk("upd1_counts", {24'd0, catch_count, miss_count}, 32'd0);
      run_pass(-1, -1);
      for (int k = 32; k < 48; k++)
         chk("p2_square1_erase", {14'd0, cap[k]},
             {14'd0, 8'(40 + (k - 32) % 4), 7'(30 + (k - 32) / 4), BG});
      for (int k = 48; k < 64; k++)
         chk("p2_square1_draw", {14'd0, cap[k]},
             {14'd0, 8'(40 + (k - 48) % 4), 7'(31 + (k - 48) / 4), SQ});

      // square 3 reaches y=116 after 26 updates; the 27th lands it under the catcher
      repeat (25) do_update(8'd0);
      do_update(8'd120);
      chk("catch_counts", {24'd0, catch_count, miss_count}, {24'd0, 4'd1, 4'd0});
      run_pass(-1, -1);
      chk("counts_persist", {24'd0, catch_count, miss_count}, {24'd0, 4'd1, 4'd0});

      run_pass(-1, 20);
      run_pass(-1, -1);

      run_pass(50, -1);
      run_pass(-1, -1);
      chk("restart_first_pixel", {14'd0, cap[0]}, {14'd0, 8'd0, 7'd0, BG});

      repeat (26) do_update(8'd0);
      do_update(8'd0);
      chk("miss_counts", {24'd0, catch_count, miss_count}, {24'd0, 4'd0, 4'd1});
      run_pass(-1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/square_field.md
Name: square_field

Overview:
- Datapath stage directly downstream of the game control FSM.
- Owns the positions of the falling squares and advances them one step on each `update` pulse.
- Rasterises the squares to the VGA pixel interface while `draw_squares` is high, then returns `finish_drawing_squares`.
- Reports per-update catch/miss counts, judged against the catcher position, for the score stage.

Parameters:
- N_SQUARES, 4, number of falling squares (1..8)
- SIZE, 4, square edge in pixels
- STEP, 1, rows fallen per update
- SCREEN_W, 160, screen width in pixels (SCREEN_W-SIZE must be >= 128)
- SCREEN_H, 120, screen height in pixels
- CATCHER_W, 16, catcher width in pixels
- SQ_COLOUR, 3'b100, square colour
- BG_COLOUR, 3'b000, background colour

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- update  in  1  one-cycle pulse from control: advance all squares
- draw_squares  in  1  level from control: rasterise while high
- catcher_x  in  8  left column of the catcher
- x_out  out  8  pixel column
- y_out  out  7  pixel row
- colour  out  3  pixel colour
- pixel_valid  out  1  x_out/y_out/colour valid this cycle
- finish_drawing_squares  out  1  raster pass complete
- catch_count  out  4  squares caught in last update
- miss_count  out  4  squares missed in last update
- stats_valid  out  1  one-cycle pulse: counts updated

Behaviour:
- Reset, asynchronous, while reset=0:
  - square i: x=i*(SCREEN_W/N_SQUARES), y=i*(SCREEN_H/N_SQUARES), prev_x/prev_y equal to x/y
  - LFSR=8'hA5
  - FSM=IDLE
  - all outputs 0
- Reset asserted mid-pass aborts the pass immediately; no further pixels are emitted.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; advances every clock.
  - Respawn value r_i = LFSR rotated left by i.
  - Respawn column x = r_i >= (SCREEN_W-SIZE) ? r_i-(SCREEN_W-SIZE) : r_i.
- Update (accepted only in IDLE; ignored in any other state), all squares evaluated in parallel in one cycle:
  - If y_i+STEP+SIZE > SCREEN_H, square i lands.
  - It counts as caught if x_i+SIZE > catcher_x and x_i < catcher_x+CATCHER_W; otherwise it counts as missed.
  - A landed square respawns at y=0, x=respawn column.
  - A square that has not landed moves to y_i+STEP; x is unchanged.
  - prev_x/prev_y are not modified by an update.
  - catch_count/miss_count are registered and stats_valid pulses in the cycle after the update cycle.
  - Counts persist until the next update.
- FSM states: IDLE, ERASE, DRAW, DONE. Square index s and offsets px, py run 0..SIZE-1, px fastest.
  - IDLE: draw_squares=1 -> ERASE with s=0, px=py=0.
  - ERASE: emits pixel (prev_x_s+px, prev_y_s+py) in BG_COLOUR. After px=py=SIZE-1 -> DRAW.
  - DRAW: emits pixel (x_s+px, y_s+py) in SQ_COLOUR. After the last pixel:
    - prev_s <= (x_s, y_s);
    - if s<N_SQUARES-1, then s++ and -> ERASE;
    - else -> DONE.
  - DONE: finish_drawing_squares=1. Held while draw_squares=1; draw_squares=0 -> IDLE with finish deasserted.
  - draw_squares dropping mid-pass is ignored; the pass completes.
- Pixel outputs are registered:
  - first pixel_valid occurs the cycle after draw_squares is first sampled high in IDLE;
  - exactly 2*N_SQUARES*SIZE*SIZE consecutive valid cycles follow (128 with defaults);
  - finish_drawing_squares rises the cycle after the last valid pixel.
- When pixel_valid=0, x_out/y_out/colour hold their last values.
- Widths: all coordinate sums are computed at 9 bits before compare; no wrap-around of x or y is permitted.

Test Plan:
- Reset release, then draw_squares held high -> 128 consecutive pixel_valid cycles; first pixel (0,0) BG_COLOUR; pixels 16..31 SQ_COLOUR at x 0..3, y 0..3; finish rises the next cycle.
- One update, then a draw pass -> square 1 erased at (40..43, 30..33), then drawn at (40..43, 31..34); stats_valid pulses with catch_count=0, miss_count=0.
- Square 3 starts at y=90; after 26 updates it sits at y=116; the 27th update with catcher_x=120 lands it -> catch_count=1, square 3 respawns at y=0 with x=respawn column.
- Same landing with catcher_x=0 -> miss_count=1, catch_count=0.
- update pulsed during DRAW -> positions unchanged; no stats_valid pulse.
- reset asserted at pixel 50 of a pass -> outputs go to 0 immediately and positions return to their initial values; the next pass starts again at pixel (0,0).
